// File: rtl/mem_pkg.sv
// Shared definitions for the LSU <-> memory request/response interface.
package mem_pkg;

  localparam int MEM_DATA_WIDTH = 64;
  localparam int MEM_ADDR_WIDTH = 64;
  localparam int MEM_TAG_WIDTH  = 4;

  typedef struct packed {
    logic [MEM_ADDR_WIDTH-1:0] addr;
    logic [MEM_TAG_WIDTH-1:0]  tag;
    logic                      store;
    logic [MEM_DATA_WIDTH-1:0] wdata;
  } mem_req_t;

  typedef struct packed {
    logic [MEM_TAG_WIDTH-1:0]  tag;
    logic [MEM_DATA_WIDTH-1:0] data;
    logic                      store;
    logic                      err;
  } mem_resp_t;

endpackage

// File: rtl/resp_fifo.sv
// Synchronous response FIFO of mem_resp_t; the head is presented combinationally
// and reads as all-zero while the FIFO is empty.
module resp_fifo
  import mem_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic      clk_in,
  input  logic      rst_in,
  input  logic      clear_in,
  input  logic      push_in,
  input  mem_resp_t push_data_in,
  input  logic      pop_in,
  output mem_resp_t head_out,
  output logic      full_out,
  output logic      empty_out
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam logic [PTR_W-1:0] LAST_IDX = PTR_W'(DEPTH - 1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  logic [PTR_W-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             do_push, do_pop;
  mem_resp_t        store_q [DEPTH];

  // Occupancy-based pointer update; pointers wrap explicitly so any DEPTH works.
  always_comb begin
    empty_out = (cnt_q == '0);
    full_out  = (cnt_q == FULL_CNT);
    do_pop    = pop_in && !empty_out;
    do_push   = push_in && (!full_out || do_pop);
    head_out  = empty_out ? '0 : store_q[rd_q];
    wr_d      = wr_q;
    rd_d      = rd_q;
    cnt_d     = cnt_q;
    if (clear_in) begin
      wr_d  = '0;
      rd_d  = '0;
      cnt_d = '0;
    end else begin
      if (do_push) wr_d = (wr_q == LAST_IDX) ? '0 : wr_q + PTR_W'(1);
      if (do_pop)  rd_d = (rd_q == LAST_IDX) ? '0 : rd_q + PTR_W'(1);
      cnt_d = cnt_q + CNT_W'(do_push) - CNT_W'(do_pop);
    end
  end

  // Pointer and occupancy registers.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  end

  // Entry storage; contents only matter while counted as occupied.
  always_ff @(posedge clk_in) begin
    if (do_push && !clear_in) store_q[wr_q] <= push_data_in;
  end

endmodule

// File: rtl/lsu_mem_responder.sv
// Memory-side responder for the LSU: services tagged loads/stores against a
// local word array and returns in-order responses after a fixed latency.
module lsu_mem_responder
  import mem_pkg::*;
#(
  parameter int DATA_WIDTH = MEM_DATA_WIDTH,
  parameter int ADDR_WIDTH = MEM_ADDR_WIDTH,
  parameter int TAG_WIDTH  = MEM_TAG_WIDTH,
  parameter int MEM_WORDS  = 256,
  parameter int LATENCY    = 3,
  parameter int RESP_DEPTH = 4
) (
  input  logic                  clk_in,
  input  logic                  rst_in,
  input  logic                  flush_in,
  input  logic                  req_valid_in,
  output logic                  req_ready_out,
  input  logic [ADDR_WIDTH-1:0] req_addr_in,
  input  logic [TAG_WIDTH-1:0]  req_tag_in,
  input  logic                  req_store_in,
  input  logic [DATA_WIDTH-1:0] req_wdata_in,
  output logic                  resp_valid_out,
  input  logic                  resp_ready_in,
  output logic [TAG_WIDTH-1:0]  resp_tag_out,
  output logic [DATA_WIDTH-1:0] resp_data_out,
  output logic                  resp_store_out,
  output logic                  resp_err_out
);

  localparam int IDX_W = $clog2(MEM_WORDS);
  localparam int CNT_W = $clog2(RESP_DEPTH) + 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(RESP_DEPTH);

  mem_req_t              req;
  logic [IDX_W-1:0]      req_idx;
  logic                  req_err, accept, mem_we;
  logic [DATA_WIDTH-1:0] mem_q [MEM_WORDS];
  logic [LATENCY-1:0]    pipe_valid_q, pipe_valid_d;
  mem_resp_t             pipe_q [LATENCY];
  mem_resp_t             pipe_d [LATENCY];
  logic [CNT_W-1:0]      count_q, count_d;
  mem_resp_t             fifo_head;
  logic                  fifo_empty, fifo_full, fifo_push, fifo_pop;

  // Request decode, address checking and the credit-based accept decision.
  always_comb begin
    req = '{addr: req_addr_in, tag: req_tag_in, store: req_store_in, wdata: req_wdata_in};
    req_idx       = req.addr[3 +: IDX_W];
    req_err       = (req.addr[2:0] != 3'b000) || ((req.addr >> (3 + IDX_W)) != '0);
    req_ready_out = (count_q < CNT_MAX) && !flush_in;
    accept        = req_valid_in && req_ready_out;
    mem_we        = accept && req.store && !req_err;
  end

  // Data array write; deliberately not reset so stored data survives reset.
  always_ff @(posedge clk_in) begin
    if (mem_we) mem_q[req_idx] <= req.wdata;
  end

  // Stage 0 captures the access result; later stages shift unconditionally.
  always_comb begin
    pipe_valid_d    = '0;
    pipe_valid_d[0] = accept;
    pipe_d[0].tag   = req.tag;
    pipe_d[0].store = req.store;
    pipe_d[0].err   = req_err;
    pipe_d[0].data  = (!req.store && !req_err) ? mem_q[req_idx] : '0;
    for (int i = 1; i < LATENCY; i++) begin
      pipe_valid_d[i] = pipe_valid_q[i-1];
      pipe_d[i]       = pipe_q[i-1];
    end
    if (flush_in) pipe_valid_d = '0;
  end

  // Pipeline registers.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      pipe_valid_q <= '0;
      for (int i = 0; i < LATENCY; i++) pipe_q[i] <= '0;
    end else begin
      pipe_valid_q <= pipe_valid_d;
      for (int i = 0; i < LATENCY; i++) pipe_q[i] <= pipe_d[i];
    end
  end

  // FIFO handshake and outstanding-request bookkeeping; flush wins over everything.
  always_comb begin
    fifo_push = pipe_valid_q[LATENCY-1] && !flush_in && (!fifo_full || fifo_pop);
    fifo_pop  = !fifo_empty && resp_ready_in && !flush_in;
    if (flush_in) count_d = '0;
    else          count_d = count_q + CNT_W'(accept) - CNT_W'(fifo_pop);
  end

  // Outstanding counter register.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) count_q <= '0;
    else        count_q <= count_d;
  end

  resp_fifo #(
    .DEPTH(RESP_DEPTH)
  ) u_resp_fifo (
    .clk_in       (clk_in),
    .rst_in       (rst_in),
    .clear_in     (flush_in),
    .push_in      (fifo_push),
    .push_data_in (pipe_q[LATENCY-1]),
    .pop_in       (fifo_pop),
    .head_out     (fifo_head),
    .full_out     (fifo_full),
    .empty_out    (fifo_empty)
  );

  // Response port driven straight from the FIFO head.
  always_comb begin
    resp_valid_out = !fifo_empty;
    resp_tag_out   = fifo_head.tag;
    resp_data_out  = fifo_head.data;
    resp_store_out = fifo_head.store;
    resp_err_out   = fifo_head.err;
  end

endmodule

// File: tb/tb_lsu_mem_responder.sv
// Bench for lsu_mem_responder: directed scenarios plus randomized traffic,
// compared every cycle against an in-order queue model of the responder.
module tb_lsu_mem_responder;

  localparam int LAT   = 3;
  localparam int DEPTH = 4;
  localparam int WORDS = 256;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        flush_in = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [63:0] req_addr = '0;
  logic [3:0]  req_tag = '0;
  logic        req_store = 1'b0;
  logic [63:0] req_wdata = '0;
  logic        resp_valid;
  logic        resp_ready = 1'b0;
  logic [3:0]  resp_tag;
  logic [63:0] resp_data;
  logic        resp_store;
  logic        resp_err;

  int total = 0;
  int bad   = 0;

  lsu_mem_responder #(
    .DATA_WIDTH(64), .ADDR_WIDTH(64), .TAG_WIDTH(4),
    .MEM_WORDS(WORDS), .LATENCY(LAT), .RESP_DEPTH(DEPTH)
  ) dut (
    .clk_in(clk), .rst_in(rst), .flush_in(flush_in),
    .req_valid_in(req_valid), .req_ready_out(req_ready),
    .req_addr_in(req_addr), .req_tag_in(req_tag),
    .req_store_in(req_store), .req_wdata_in(req_wdata),
    .resp_valid_out(resp_valid), .resp_ready_in(resp_ready),
    .resp_tag_out(resp_tag), .resp_data_out(resp_data),
    .resp_store_out(resp_store), .resp_err_out(resp_err)
  );

  always #5 clk = ~clk;

  // Expected responses in acceptance order; a response becomes visible at ready_edge.
  typedef struct {
    logic [3:0]  tag;
    logic [63:0] data;
    logic        store;
    logic        err;
    bit          known;
    int          ready_edge;
  } exp_t;

  exp_t        exp_q[$];
  logic [63:0] mem_m [int];
  int          edge_n = 0;
  bit          m_ready, m_valid, m_acc, m_pop, m_err;
  int          m_idx;
  exp_t        m_e;
  bit          c_valid;

  task automatic check_output(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: a credit-limited in-order queue with a fixed visibility delay.
  always @(posedge clk) begin
    if (rst) begin
      exp_q.delete();
    end else begin
      m_ready = (exp_q.size() < DEPTH) && !flush_in;
      m_valid = (exp_q.size() > 0) && (exp_q[0].ready_edge <= edge_n);
      m_acc   = req_valid && m_ready;
      m_pop   = m_valid && resp_ready && !flush_in;
      if (flush_in) begin
        exp_q.delete();
      end else begin
        if (m_pop) void'(exp_q.pop_front());
        if (m_acc) begin
          m_err        = (req_addr % 8 != 0) || (req_addr / 8 >= WORDS);
          m_e.tag      = req_tag;
          m_e.store    = req_store;
          m_e.err      = m_err;
          m_e.data     = '0;
          m_e.known    = 1'b1;
          m_e.ready_edge = edge_n + 1 + LAT;
          if (!m_err) begin
            m_idx = int'(req_addr / 8);
            if (req_store) mem_m[m_idx] = req_wdata;
            else if (mem_m.exists(m_idx)) m_e.data = mem_m[m_idx];
            else m_e.known = 1'b0;
          end
          exp_q.push_back(m_e);
        end
      end
    end
    edge_n++;
  end

  // Every-cycle comparison of the DUT against the model.
  always @(negedge clk) begin
    if (!rst) begin
      c_valid = (exp_q.size() > 0) && (exp_q[0].ready_edge <= edge_n);
      check_output("req_ready", 64'(req_ready), 64'((exp_q.size() < DEPTH) && !flush_in));
      check_output("resp_valid", 64'(resp_valid), 64'(c_valid));
      if (c_valid && resp_valid) begin
        check_output("resp_tag", 64'(resp_tag), 64'(exp_q[0].tag));
        check_output("resp_store", 64'(resp_store), 64'(exp_q[0].store));
        check_output("resp_err", 64'(resp_err), 64'(exp_q[0].err));
        if (exp_q[0].known) check_output("resp_data", resp_data, exp_q[0].data);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_stimulus(input logic v, input logic [63:0] a, input logic [3:0] t,
                                input logic s, input logic [63:0] w);
    req_valid = v;
    req_addr  = a;
    req_tag   = t;
    req_store = s;
    req_wdata = w;
  endtask

  task automatic drain(input int n);
    apply_stimulus(1'b0, '0, '0, 1'b0, '0);
    resp_ready = 1'b1;
    flush_in   = 1'b0;
    repeat (n) step();
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  logic [63:0] r_addr;
  int          sel;

  initial begin
    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_output("rst_ready", 64'(req_ready), 64'd1);
    check_output("rst_valid", 64'(resp_valid), 64'd0);
    check_output("rst_tag", 64'(resp_tag), 64'd0);
    check_output("rst_data", resp_data, 64'd0);
    check_output("rst_store", 64'(resp_store), 64'd0);
    check_output("rst_err", 64'(resp_err), 64'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    resp_ready = 1'b1;

    // Store then load to the same word on consecutive cycles
    apply_stimulus(1'b1, 64'h40, 4'd1, 1'b1, 64'hDEAD_BEEF);
    step();
    apply_stimulus(1'b1, 64'h40, 4'd2, 1'b0, '0);
    step();
    apply_stimulus(1'b0, '0, '0, 1'b0, '0);
    step();
    step();
    @(negedge clk);
    check_output("t1_valid", 64'(resp_valid), 64'd1);
    check_output("t1_tag1", 64'(resp_tag), 64'd1);
    check_output("t1_store1", 64'(resp_store), 64'd1);
    check_output("t1_data1", resp_data, 64'd0);
    step();
    @(negedge clk);
    check_output("t1_tag2", 64'(resp_tag), 64'd2);
    check_output("t1_data2", resp_data, 64'hDEAD_BEEF);
    check_output("t1_store2", 64'(resp_store), 64'd0);
    drain(6);

    // Back-pressure: five loads with the consumer stalled
    resp_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      apply_stimulus(1'b1, 64'h40, 4'(k), 1'b0, '0);
      step();
    end
    @(negedge clk);
    check_output("t2_ready_full", 64'(req_ready), 64'd0);
    step();
    step();
    resp_ready = 1'b1;
    step();
    @(negedge clk);
    check_output("t2_ready_after_pop", 64'(req_ready), 64'd1);
    check_output("t2_head_tag", 64'(resp_tag), 64'd1);
    step();
    drain(10);

    // Full counter, then streaming with simultaneous accept and pop
    resp_ready = 1'b0;
    for (int k = 0; k < 4; k++) begin
      apply_stimulus(1'b1, 64'h40, 4'(8 + k), 1'b0, '0);
      step();
    end
    apply_stimulus(1'b0, '0, '0, 1'b0, '0);
    repeat (3) step();
    resp_ready = 1'b1;
    for (int k = 0; k < 10; k++) begin
      apply_stimulus(1'b1, 64'h40, 4'(k), 1'b0, '0);
      step();
    end
    drain(10);

    // Error addresses, then a clean load of a written word
    apply_stimulus(1'b1, 64'h43, 4'd3, 1'b0, '0);
    step();
    apply_stimulus(1'b1, 64'h1_0000, 4'd4, 1'b0, '0);
    step();
    apply_stimulus(1'b1, 64'h40, 4'd5, 1'b0, '0);
    step();
    apply_stimulus(1'b0, '0, '0, 1'b0, '0);
    step();
    @(negedge clk);
    check_output("t4_err_a", 64'(resp_err), 64'd1);
    check_output("t4_data_a", resp_data, 64'd0);
    check_output("t4_tag_a", 64'(resp_tag), 64'd3);
    step();
    @(negedge clk);
    check_output("t4_err_b", 64'(resp_err), 64'd1);
    check_output("t4_data_b", resp_data, 64'd0);
    step();
    @(negedge clk);
    check_output("t4_err_c", 64'(resp_err), 64'd0);
    check_output("t4_data_c", resp_data, 64'hDEAD_BEEF);
    drain(6);

    // Flush after two accepted loads
    apply_stimulus(1'b1, 64'h40, 4'd1, 1'b0, '0);
    step();
    apply_stimulus(1'b1, 64'h40, 4'd2, 1'b0, '0);
    step();
    apply_stimulus(1'b1, 64'h40, 4'd3, 1'b0, '0);
    flush_in = 1'b1;
    @(negedge clk);
    check_output("t5_ready_in_flush", 64'(req_ready), 64'd0);
    step();
    flush_in = 1'b0;
    apply_stimulus(1'b0, '0, '0, 1'b0, '0);
    @(negedge clk);
    check_output("t5_ready_after", 64'(req_ready), 64'd1);
    for (int k = 0; k < 4; k++) begin
      step();
      @(negedge clk);
      check_output("t5_no_resp", 64'(resp_valid), 64'd0);
    end
    drain(2);

    // Asynchronous reset with two responses waiting
    resp_ready = 1'b0;
    apply_stimulus(1'b1, 64'h40, 4'd6, 1'b0, '0);
    step();
    apply_stimulus(1'b1, 64'h40, 4'd7, 1'b0, '0);
    step();
    apply_stimulus(1'b0, '0, '0, 1'b0, '0);
    repeat (3) step();
    @(negedge clk);
    check_output("t6_valid_before", 64'(resp_valid), 64'd1);
    step();
    #2 rst = 1'b1;
    #1;
    check_output("t6_rst_valid", 64'(resp_valid), 64'd0);
    check_output("t6_rst_tag", 64'(resp_tag), 64'd0);
    check_output("t6_rst_data", resp_data, 64'd0);
    check_output("t6_rst_ready", 64'(req_ready), 64'd1);
    @(posedge clk);
    #2 rst = 1'b0;
    resp_ready = 1'b1;
    step();
    apply_stimulus(1'b1, 64'h40, 4'd9, 1'b0, '0);
    step();
    apply_stimulus(1'b0, '0, '0, 1'b0, '0);
    repeat (3) step();
    @(negedge clk);
    check_output("t6_tag_after", 64'(resp_tag), 64'd9);
    check_output("t6_data_after", resp_data, 64'hDEAD_BEEF);
    drain(4);

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      sel = $urandom_range(0, 9);
      if (sel < 8)       r_addr = 64'(sel) << 3;
      else if (sel == 8) r_addr = (64'($urandom_range(0, 255)) << 3) | 64'($urandom_range(1, 7));
      else               r_addr = {$urandom, $urandom} | 64'h800;
      apply_stimulus($urandom_range(0, 99) < 70, r_addr, 4'($urandom),
                     $urandom_range(0, 99) < 40, {$urandom, $urandom});
      resp_ready = $urandom_range(0, 99) < 60;
      flush_in   = $urandom_range(0, 99) < 3;
      step();
    end
    drain(12);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
